dvi_rx_word_align: RTL and testbench
====================================

// Module: dvi_rx_word_align
// PURPOSE
//  Receive-side counterpart of the DVI transmit path. Takes raw 10-bit words from a
//  per-lane 10:1 input deserialiser, whose word boundary is arbitrary, and finds the
//  TMDS symbol boundary by hunting for runs of control tokens during blanking.
//  Outputs aligned symbols, a lock flag and the decoded control bits to the TMDS
//  decoder. One instance per lane, in the pixel clock domain.
// PARAMETERS
//  CTRL_RUN  8     consecutive control tokens at current offset needed to declare lock
//  TIMEOUT   4096  pixel cycles without any control token before offset is abandoned
// PORTS
//  clk        in   1   pixel clock
//  rst_n      in   1   asynchronous active-low reset
//  d_in       in   10  raw deserialised word; bit 0 is the earliest received bit
//  resync     in   1   pulse: drop lock, advance offset, restart search
//  sym_out    out  10  aligned TMDS symbol; bit 0 is the earliest bit
//  is_ctrl    out  1   sym_out is one of the four control tokens
//  ctrl       out  2   decoded {c1,c0} when is_ctrl; 0 otherwise
//  locked     out  1   alignment found and held
//  offs       out  4   current bit offset, 0..9
// BEHAVIOUR
//  - Reset: prev=0, sym_out=0, is_ctrl=0, ctrl=0, locked=0, offs=0, state=SEARCH,
//    run_ctr=0, to_ctr=0.
//  - Every cycle: prev<=d_in. window={d_in,prev} (20b). slice=window[offs+:10].
//    sym_out/is_ctrl/ctrl are registered from slice, so latency d_in->sym_out is
//    2 cycles at offs=0 and 1 cycle at offs=9 (bit-exact).
//  - Tokens, as sym[9:0]: 10'h354->00, 10'h0AB->01, 10'h154->10, 10'h2AB->11.
//  - match = slice is a token. It is evaluated on the slice, not on the registered output.
//  - SEARCH: match -> run_ctr++, to_ctr=0. !match -> run_ctr=0, to_ctr++.
//    run_ctr reaches CTRL_RUN-1 with match -> LOCKED, locked=1 next cycle, counters cleared.
//    to_ctr reaches TIMEOUT-1 with !match -> offs advances, counters cleared.
//  - LOCKED: match -> to_ctr=0. !match -> to_ctr++. to_ctr reaches TIMEOUT-1 with !match
//    -> SEARCH, locked=0, offs advances, counters cleared. run_ctr is unused here.
//  - Offset advance: offs = (offs==9) ? 0 : offs+1. The new offs takes effect on the
//    next cycle's slice.
//  - resync=1: highest priority in either state. -> SEARCH, locked=0, offs advances,
//    counters cleared. This beats a same-cycle lock or timeout; offs advances once only.
//  - sym_out is not gated by locked. The consumer qualifies it with locked.
//  - Counters saturate-safe: widths are $clog2(CTRL_RUN+1) and $clog2(TIMEOUT+1).
//  - Async reset mid-operation returns all state to the reset values immediately.
// STRUCTURE
//  - Shared include tmds_defs.vh: the four token localparams (TMDS_CTRL_00..11), shared
//    with the TMDS encoder/decoder.
//  - Sub-module tmds_token_match: combinational, 10b in -> match, ctrl[1:0].
//    Instantiated once on the slice.
//  - Top level holds the prev register, the barrel slice, the 2-state FSM, the counters
//    and the output registers.
// TESTING (use CTRL_RUN=8, TIMEOUT=64 for sim)
//  1. Reset: hold rst_n=0 with random d_in -> all outputs 0, offs=0; outputs stay 0 while
//     in reset.
//  2. Aligned stream: 20 tokens of 10'h354 with 0-bit skew -> locked=1 on the 9th
//     cycle after the first token reaches the slice; sym_out=10'h354, ctrl=00, offs=0.
//  3. Skewed stream: bitstream shifted by 7 bits, blanking runs of 12 tokens every 100
//     cycles -> offs steps 0..7 on 64-cycle timeouts, then locks at offs=7; decoded
//     ctrl sequence matches the sent sequence.
//  4. Loss of lock: once locked, send 64 data symbols with no tokens -> locked falls
//     after the 64th, offs=8, state SEARCH. With 63 symbols, lock is held.
//  5. resync pulse on the same cycle that the 8th token arrives -> locked stays 0 and
//     offs advances by exactly 1.
//  6. Wrap: skew 0 but force a start at offs=9 via 9 resync pulses -> the next timeout
//     gives offs=0, and lock is then regained.

Source files
------------

// File: rtl/dvi_rx_word_align_pkg.sv
// rtl/dvi_rx_word_align_pkg.sv - shared TMDS control tokens, aligner state type and offset helper
package dvi_rx_word_align_pkg;

  // The four TMDS control tokens as sym[9:0], bit 0 earliest on the wire
  localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
  localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
  localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
  localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

  typedef enum logic {
    ST_SEARCH,
    ST_LOCKED
  } align_state_t;

  // Bit offsets cycle through 0..9 so every word phase is eventually tried
  function automatic logic [3:0] next_offs(input logic [3:0] o);
    return (o == 4'd9) ? 4'd0 : o + 4'd1;
  endfunction

endpackage

// File: rtl/dvi_rx_word_align_if.sv
// rtl/dvi_rx_word_align_if.sv - per-lane raw word input and aligned symbol output bundle
interface dvi_rx_word_align_if;
  logic [9:0] d_in;
  logic       resync;
  logic [9:0] sym_out;
  logic       is_ctrl;
  logic [1:0] ctrl;
  logic       locked;
  logic [3:0] offs;

  // master: deserialiser/consumer side; slave: the aligner
  modport master (
    output d_in, resync,
    input  sym_out, is_ctrl, ctrl, locked, offs
  );

  modport slave (
    input  d_in, resync,
    output sym_out, is_ctrl, ctrl, locked, offs
  );
endinterface

// File: rtl/dvi_rx_word_align_token_match.sv
// rtl/dvi_rx_word_align_token_match.sv - combinational TMDS control token detector and decoder
module dvi_rx_word_align_token_match
  import dvi_rx_word_align_pkg::*;
(
  input  logic [9:0] sym,
  output logic       match,
  output logic [1:0] ctrl
);

  // Decode {c1,c0}; ctrl stays 0 for anything that is not a control token
  always_comb begin
    match = 1'b1;
    ctrl  = 2'b00;
    case (sym)
      TMDS_CTRL_00: ctrl = 2'b00;
      TMDS_CTRL_01: ctrl = 2'b01;
      TMDS_CTRL_10: ctrl = 2'b10;
      TMDS_CTRL_11: ctrl = 2'b11;
      default:      match = 1'b0;
    endcase
  end

endmodule

// File: rtl/dvi_rx_word_align.sv
// rtl/dvi_rx_word_align.sv - TMDS symbol boundary search and lock for one DVI receive lane
module dvi_rx_word_align
  import dvi_rx_word_align_pkg::*;
#(
  parameter int CTRL_RUN = 8,
  parameter int TIMEOUT  = 4096
) (
  input logic                 clk,
  input logic                 rst_n,
  dvi_rx_word_align_if.slave  bus
);

  localparam int RW = $clog2(CTRL_RUN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(CTRL_RUN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  align_state_t  state;
  logic [9:0]    prev;
  logic [19:0]   window;
  logic [9:0]    slice;
  logic          match;
  logic [1:0]    slice_ctrl;
  logic [9:0]    sym_q;
  logic          is_ctrl_q;
  logic [1:0]    ctrl_q;
  logic          locked_q;
  logic [3:0]    offs_q;
  logic [RW-1:0] run_ctr;
  logic [TW-1:0] to_ctr;

  // Older word sits in the low half so bit 0 of the window is the earliest bit
  assign window = {bus.d_in, prev};
  assign slice  = 10'(window >> offs_q);

  dvi_rx_word_align_token_match u_match (
    .sym   (slice),
    .match (match),
    .ctrl  (slice_ctrl)
  );

  assign bus.sym_out = sym_q;
  assign bus.is_ctrl = is_ctrl_q;
  assign bus.ctrl    = ctrl_q;
  assign bus.locked  = locked_q;
  assign bus.offs    = offs_q;

  // Previous-word register and registered slice outputs; output is not gated by lock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev      <= '0;
      sym_q     <= '0;
      is_ctrl_q <= 1'b0;
      ctrl_q    <= 2'b00;
    end else begin
      prev      <= bus.d_in;
      sym_q     <= slice;
      is_ctrl_q <= match;
      ctrl_q    <= slice_ctrl;
    end
  end

  // Search/lock FSM; resync outranks a same-cycle lock or timeout and advances offs once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_SEARCH;
      locked_q <= 1'b0;
      offs_q   <= 4'd0;
      run_ctr  <= '0;
      to_ctr   <= '0;
    end else if (bus.resync) begin
      state    <= ST_SEARCH;
      locked_q <= 1'b0;
      offs_q   <= next_offs(offs_q);
      run_ctr  <= '0;
      to_ctr   <= '0;
    end else begin
      case (state)
        ST_SEARCH: begin
          if (match) begin
            if (run_ctr == RUN_LAST) begin
              state    <= ST_LOCKED;
              locked_q <= 1'b1;
              run_ctr  <= '0;
            end else begin
              run_ctr <= run_ctr + RW'(1);
            end
            to_ctr <= '0;
          end else if (to_ctr == TO_LAST) begin
            offs_q  <= next_offs(offs_q);
            run_ctr <= '0;
            to_ctr  <= '0;
          end else begin
            run_ctr <= '0;
            to_ctr  <= to_ctr + TW'(1);
          end
        end
        ST_LOCKED: begin
          if (match) begin
            to_ctr <= '0;
          end else if (to_ctr == TO_LAST) begin
            state    <= ST_SEARCH;
            locked_q <= 1'b0;
            offs_q   <= next_offs(offs_q);
            run_ctr  <= '0;
            to_ctr   <= '0;
          end else begin
            to_ctr <= to_ctr + TW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dvi_rx_word_align.sv
// tb/tb_dvi_rx_word_align.sv - self-checking bench for dvi_rx_word_align
module tb_dvi_rx_word_align;

  localparam int CTRL_RUN = 8;
  localparam int TIMEOUT  = 64;
  localparam logic [9:0] TOK_TAB [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dvi_rx_word_align_if bus ();

  dvi_rx_word_align #(.CTRL_RUN(CTRL_RUN), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  function automatic int tok_idx(input logic [9:0] v);
    for (int t = 0; t < 4; t++) if (v == TOK_TAB[t]) return t;
    return -1;
  endfunction

  // Reference model: a 20-bit history of the received bit stream, oldest first,
  // from which the symbol at the current offset is read, plus run/silence counts.
  bit         hq[$];
  int         m_offs, m_run, m_silent;
  bit         m_locked;
  logic [9:0] e_sym;
  bit         e_is;
  logic [1:0] e_ctrl;

  function automatic void model_reset();
    hq.delete();
    for (int i = 0; i < 20; i++) hq.push_back(1'b0);
    m_offs = 0; m_run = 0; m_silent = 0; m_locked = 0;
    e_sym = '0; e_is = 0; e_ctrl = '0;
  endfunction

  function automatic void model_step(input logic [9:0] d, input bit rs);
    logic [9:0] s;
    int hit;
    for (int i = 0; i < 10; i++) void'(hq.pop_front());
    for (int i = 0; i < 10; i++) hq.push_back(d[i]);
    for (int i = 0; i < 10; i++) s[i] = hq[m_offs + i];
    hit    = tok_idx(s);
    e_sym  = s;
    e_is   = (hit >= 0);
    e_ctrl = (hit >= 0) ? 2'(hit) : 2'b00;
    if (rs) begin
      m_locked = 0; m_offs = (m_offs + 1) % 10; m_run = 0; m_silent = 0;
    end else if (hit >= 0) begin
      m_silent = 0;
      if (!m_locked) begin
        m_run++;
        if (m_run == CTRL_RUN) begin m_locked = 1; m_run = 0; end
      end
    end else begin
      m_run = 0;
      m_silent++;
      if (m_silent == TIMEOUT) begin
        m_locked = 0; m_offs = (m_offs + 1) % 10; m_silent = 0;
      end
    end
  endfunction

  // Called between edges; drives one word, clocks once, checks against the model
  task automatic step(input logic [9:0] d, input bit rs);
    bus.d_in   = d;
    bus.resync = rs;
    model_step(d, rs);
    @(posedge clk);
    #1;
    check("model_sym",     bus.sym_out, e_sym);
    check("model_is_ctrl", bus.is_ctrl, e_is);
    check("model_ctrl",    bus.ctrl,    e_ctrl);
    check("model_locked",  bus.locked,  m_locked);
    check("model_offs",    bus.offs,    m_offs);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sym"},     bus.sym_out, 0);
    check({tag, "_is_ctrl"}, bus.is_ctrl, 0);
    check({tag, "_ctrl"},    bus.ctrl,    0);
    check({tag, "_locked"},  bus.locked,  0);
    check({tag, "_offs"},    bus.offs,    0);
  endtask

  // Asserted between edges so the clear is seen without a clock
  task automatic do_reset();
    bus.resync = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero("async_reset");
    for (int i = 0; i < 3; i++) begin
      bus.d_in = 10'($urandom);
      @(posedge clk);
      #1;
      check_zero("held_reset");
    end
    #2;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         rst;
    logic [9:0] d;
    bit         rs;
    logic [9:0] e_sym;
    bit         e_is;
    logic [1:0] e_ctrl;
    bit         e_lock;
    logic [3:0] e_offs;
  } vec_t;

  vec_t tv[$];

  function automatic void addv(input bit r, input logic [9:0] d, input bit rs, input logic [9:0] es,
                               input bit ei, input logic [1:0] ec, input bit el, input logic [3:0] eo);
    vec_t v;
    v.rst = r; v.d = d; v.rs = rs; v.e_sym = es; v.e_is = ei;
    v.e_ctrl = ec; v.e_lock = el; v.e_offs = eo;
    tv.push_back(v);
  endfunction

  function automatic logic [9:0] skew_word(input logic [9:0] s, input logic [9:0] sp, input int k);
    logic [19:0] w;
    w = {s, sp};
    return 10'(w >> (10 - k));
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] v;
    do v = 10'($urandom); while (tok_idx(v) >= 0);
    return v;
  endfunction

  logic [9:0] sp;

  // Symbols are placed 7 bits late; with offs=7 sym_out after a step is the previous symbol
  task automatic feed7(input logic [9:0] s);
    int t;
    step(skew_word(s, sp, 7), 1'b0);
    if (bus.locked) begin
      t = tok_idx(sp);
      check("skew_is_ctrl", bus.is_ctrl, t >= 0);
      check("skew_ctrl",    bus.ctrl,    (t >= 0) ? t : 0);
    end
    sp = s;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int         j, last_offs, sk, rem, wrap_seen;
    bit         got_lock, tok_mode;
    logic [9:0] s, run_tok;

    bus.d_in = '0;
    bus.resync = 1'b0;
    #1;

    // Reset plus table vectors: aligned lock with two tokens, and resync colliding with lock
    for (int i = 0; i < 20; i++)
      addv(i == 0, 10'h354, 0, (i >= 1) ? 10'h354 : 10'h0, i >= 1, 2'b00, i >= 8, 4'd0);
    for (int i = 0; i < 10; i++)
      addv(i == 0, 10'h2AB, 0, (i >= 1) ? 10'h2AB : 10'h0, i >= 1, (i >= 1) ? 2'b11 : 2'b00, i >= 8, 4'd0);
    for (int i = 0; i < 9; i++)
      addv(i == 0, 10'h354, i == 8, (i >= 1) ? 10'h354 : 10'h0, i >= 1, 2'b00, 0, (i == 8) ? 4'd1 : 4'd0);
    addv(0, 10'h354, 0, 10'h1AA, 0, 2'b00, 0, 4'd1);
    addv(0, 10'h354, 0, 10'h1AA, 0, 2'b00, 0, 4'd1);

    foreach (tv[i]) begin
      if (tv[i].rst) do_reset();
      step(tv[i].d, tv[i].rs);
      check($sformatf("vec%0d_sym", i),     bus.sym_out, tv[i].e_sym);
      check($sformatf("vec%0d_is_ctrl", i), bus.is_ctrl, tv[i].e_is);
      check($sformatf("vec%0d_ctrl", i),    bus.ctrl,    tv[i].e_ctrl);
      check($sformatf("vec%0d_locked", i),  bus.locked,  tv[i].e_lock);
      check($sformatf("vec%0d_offs", i),    bus.offs,    tv[i].e_offs);
    end

    // Skewed stream: 12-token blanking every 100 symbols, 7-bit skew
    do_reset();
    sp = '0; j = 0; got_lock = 0; last_offs = 0; run_tok = TOK_TAB[0];
    while (!got_lock && j < 3000) begin
      if (j % 100 == 0) run_tok = TOK_TAB[$urandom % 4];
      s = (j % 100 < 12) ? run_tok : rand_data();
      feed7(s);
      if (int'(bus.offs) != last_offs) begin
        check("skew_offs_step", bus.offs, (last_offs + 1) % 10);
        last_offs = int'(bus.offs);
      end
      if (bus.locked) begin
        got_lock = 1;
        check("skew_lock_offs", bus.offs, 7);
      end
      j++;
    end
    if (!got_lock) bound_fail("skew_lock");

    // Loss of lock: 63 silent symbols hold, 64 drop
    while (j % 100 < 12) begin feed7(run_tok); j++; end
    for (int k = 0; k < 63; k++) feed7(rand_data());
    feed7(run_tok);
    check("hold_63_locked", bus.locked, 1);
    for (int k = 0; k < 4; k++) feed7(run_tok);
    for (int k = 0; k < 64; k++) feed7(rand_data());
    check("hold_63b_locked", bus.locked, 1);
    feed7(rand_data());
    check("drop_64_locked", bus.locked, 0);
    check("drop_64_offs",   bus.offs,   8);

    // Wrap: nine resyncs park offs at 9, next timeout wraps to 0, then relock
    do_reset();
    for (int k = 0; k < 9; k++) step(10'h354, 1'b1);
    check("wrap_pre_offs", bus.offs, 9);
    wrap_seen = 0; got_lock = 0;
    for (int k = 0; k < 200 && !got_lock; k++) begin
      step(10'h354, 1'b0);
      if (!wrap_seen && bus.offs != 4'd9) begin
        check("wrap_offs", bus.offs, 0);
        wrap_seen = 1;
      end
      if (bus.locked) got_lock = 1;
    end
    if (!got_lock) bound_fail("wrap_relock");

    // Randomised token/data bursts at changing skews, random resyncs, one async reset
    do_reset();
    sp = '0; sk = 0; rem = 0; tok_mode = 0; run_tok = TOK_TAB[0];
    for (int c = 0; c < 3000; c++) begin
      if (c % 300 == 0) sk = $urandom % 10;
      if (c == 1500) do_reset();
      if (rem == 0) begin
        tok_mode = ~tok_mode;
        rem = tok_mode ? $urandom_range(15, 4) : $urandom_range(90, 10);
        run_tok = TOK_TAB[$urandom % 4];
      end
      rem--;
      s = tok_mode ? run_tok : 10'($urandom);
      step(skew_word(s, sp, sk), ($urandom % 250) == 0);
      sp = s;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
